// File: rtl/seq_detect_monitor_pkg.sv
// Shared definitions for the sequence-detect monitor.
// State encodings are also used by downstream status logic.
package seq_detect_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_ALARM = 2'b10
  } state_t;

endpackage

// File: rtl/seq_detect_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // clear wins over increment; stop at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_monitor.sv
// Detection monitor: totals, inter-detect gap, windowed
// burst detection with a sticky alarm.
module seq_detect_monitor
  import seq_detect_monitor_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 8,
  parameter int WIN    = 16,
  parameter int THRESH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       detect,
  input  logic                       clr,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [$clog2(WIN+1)-1:0]   win_cnt,
  output logic [GAP_W-1:0]           gap,
  output logic                       gap_valid,
  output logic                       alarm
);

  localparam int WCNT_W = $clog2(WIN+1);
  localparam logic [WCNT_W-1:0] WONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WIN - 1);
  localparam logic [WCNT_W-1:0] WTHR  = WCNT_W'(THRESH);

  state_t             st;
  state_t             st_n;
  logic [WCNT_W-1:0]  win_tmr;
  logic [WCNT_W-1:0]  win_tmr_n;
  logic [WCNT_W-1:0]  win_cnt_n;
  logic [WCNT_W-1:0]  cnt_inc;
  logic [GAP_W-1:0]   timer;
  logic               have_prev;

  sat_counter #(.W(CNT_W)) u_total (
    .clk   (clk),
    .reset (reset),
    .inc   (detect),
    .clr   (clr),
    .q     (total_cnt)
  );

  sat_counter #(.W(GAP_W)) u_gap_tmr (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .clr   (clr | detect),
    .q     (timer)
  );

  // gap capture on every detect that has a predecessor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap       <= '0;
      gap_valid <= 1'b0;
      have_prev <= 1'b0;
    end else if (clr) begin
      gap       <= '0;
      gap_valid <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      gap_valid <= 1'b0;
      if (detect) begin
        have_prev <= 1'b1;
        if (have_prev) begin
          gap       <= (timer == '1) ? '1 : timer + GAP_W'(1);
          gap_valid <= 1'b1;
        end
      end
    end
  end

  // window FSM state and window registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= S_IDLE;
      win_cnt <= '0;
      win_tmr <= '0;
      alarm   <= 1'b0;
    end else begin
      st      <= st_n;
      win_cnt <= win_cnt_n;
      win_tmr <= win_tmr_n;
      alarm   <= (st_n == S_ALARM);
    end
  end

  assign cnt_inc = win_cnt + WONE;

  // next-state: open, count and close windows
  always_comb begin
    st_n      = st;
    win_cnt_n = win_cnt;
    win_tmr_n = win_tmr;
    if (clr) begin
      st_n      = S_IDLE;
      win_cnt_n = '0;
      win_tmr_n = '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (detect) begin
            win_cnt_n = WONE;
            win_tmr_n = WONE;
            st_n      = (THRESH == 1) ? S_ALARM : S_RUN;
          end
        end
        S_RUN: begin
          win_tmr_n = win_tmr + WONE;
          if (detect) win_cnt_n = cnt_inc;
          if (detect && (cnt_inc >= WTHR)) begin
            st_n = S_ALARM;
          end else if (win_tmr == WLAST) begin
            st_n = S_IDLE;
          end
        end
        S_ALARM: begin
          st_n = S_ALARM;
        end
        default: begin
          st_n = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_monitor.sv
// Self-checking bench for seq_detect_monitor.
// Directed scenarios plus random traffic against a timestamp model.
module tb_seq_detect_monitor;

  localparam int WIN    = 16;
  localparam int THRESH = 3;
  localparam int CMAX   = 255;

  logic       clk;
  logic       reset;
  logic       detect;
  logic       clr;
  logic [7:0] total_cnt;
  logic [4:0] win_cnt;
  logic [7:0] gap;
  logic       gap_valid;
  logic       alarm;

  int checks;
  int errors;

  int m_cyc, m_total, m_gap, m_gv, m_have, m_last;
  int m_alarm, m_wc, m_wstart, m_wopen;

  seq_detect_monitor #(
    .CNT_W(8), .GAP_W(8), .WIN(WIN), .THRESH(THRESH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .detect    (detect),
    .clr       (clr),
    .total_cnt (total_cnt),
    .win_cnt   (win_cnt),
    .gap       (gap),
    .gap_valid (gap_valid),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_total = 0; m_gap = 0; m_gv = 0; m_have = 0; m_last = 0;
    m_alarm = 0; m_wc = 0; m_wstart = 0; m_wopen = 0;
  endtask

  task automatic model_edge(input logic d, input logic c);
    m_cyc++;
    m_gv = 0;
    if (c) begin
      model_clear();
    end else if (d) begin
      if (m_total < CMAX) m_total++;
      if (m_have != 0) begin
        m_gap = (m_cyc - m_last > CMAX) ? CMAX : m_cyc - m_last;
        m_gv  = 1;
      end
      m_have = 1;
      m_last = m_cyc;
      if (m_alarm == 0) begin
        if (m_wopen != 0 && (m_cyc - m_wstart) < WIN) begin
          m_wc++;
        end else begin
          m_wstart = m_cyc;
          m_wc     = 1;
          m_wopen  = 1;
        end
        if (m_wc >= THRESH) m_alarm = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("total_cnt", 32'(total_cnt), 32'(m_total));
    check("win_cnt",   32'(win_cnt),   32'(m_wc));
    check("gap",       32'(gap),       32'(m_gap));
    check("gap_valid", 32'(gap_valid), 32'(m_gv));
    check("alarm",     32'(alarm),     32'(m_alarm));
  endtask

  task automatic step(input logic d, input logic c);
    detect = d;
    clr    = c;
    @(posedge clk);
    model_edge(d, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cyc  = 0;
    model_clear();
    detect = 1'b0;
    clr    = 1'b0;
    reset  = 1'b1;

    // 1: reset then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("reset_alarm", 32'(alarm), 32'd0);

    // 2: detects at 10,14,20 -> alarm
    for (int i = 1; i <= 22; i++) begin
      step(i == 10 || i == 14 || i == 20, 1'b0);
      if (i == 14) check("gap_14", 32'(gap), 32'd4);
    end
    check("gap_20", 32'(gap), 32'd6);
    check("win_20", 32'(win_cnt), 32'd3);
    check("alarm_20", 32'(alarm), 32'd1);

    // 3: detects at 10,30, window closes at 25
    step(1'b0, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      step(i == 10 || i == 30, 1'b0);
      if (i == 26) begin
        check("win_close", 32'(win_cnt), 32'd1);
        check("alarm_close", 32'(alarm), 32'd0);
      end
      if (i == 30) begin
        check("gap_30", 32'(gap), 32'd20);
        check("win_30", 32'(win_cnt), 32'd1);
      end
    end

    // 4: 300 detects every other cycle
    step(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) step(i % 2 == 0, 1'b0);
    check("total_sat", 32'(total_cnt), 32'd255);
    check("gap_2", 32'(gap), 32'd2);

    // 5: clr and detect together in alarm
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("alarm_b2b", 32'(alarm), 32'd1);
    step(1'b1, 1'b1);
    check("clr_total", 32'(total_cnt), 32'd0);
    check("clr_alarm", 32'(alarm), 32'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("clr_first", 32'(total_cnt), 32'd1);
    check("clr_nogv", 32'(gap_valid), 32'd0);

    // 6: async reset mid-window
    for (int i = 0; i < 4; i++) step(i == 2, 1'b0);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      if (i > 0) check("gap_one", 32'(gap), 32'd1);
    end
    check("alarm_rst", 32'(alarm), 32'd1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(99) < 30), ($urandom_range(199) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
